dm_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single data-memory write port among four core write requesters.
- Each requester gets a one-entry holding register with a valid/ready handshake. The arbiter issues at most one registered memory write per cycle.
- Sits between the core `to_mem`/`addr_dm`/`dm_wr` outputs and the data memory, replacing the per-core write enables with one serialized write stream.

---
 rtl/dm_wr_arbiter_if.sv | 30 +++
 rtl/dm_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_dm_wr_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dm_wr_arbiter_if.sv
// Bundle between the core write requesters and the arbiter, plus the
// serialized write stream that goes on to the data memory.
interface dm_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [GW-1:0]           grant_id;
  logic                    busy;
  logic [15:0]             wr_count;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, mem_we, mem_addr, mem_wdata, grant_id, busy, wr_count
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, mem_we, mem_addr, mem_wdata, grant_id, busy, wr_count
  );
endinterface

// File: rtl/dm_wr_arbiter.sv
// Round-robin write arbiter: N_REQ one-entry holding registers feed a single
// registered data-memory write port, one write per cycle at most.
module dm_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  dm_wr_arbiter_if.slave bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = GW + 1;

  logic [N_REQ-1:0]  hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q [N_REQ];
  logic [ADDR_W-1:0] hold_addr_d [N_REQ];
  logic [DATA_W-1:0] hold_data_q [N_REQ];
  logic [DATA_W-1:0] hold_data_d [N_REQ];
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [N_REQ-1:0]  win;
  logic              win_any;
  logic [GW-1:0]     win_idx;
  logic [N_REQ-1:0]  ready;
  logic [N_REQ-1:0]  accept;
  logic [SW-1:0]     cand_sum;
  logic [GW-1:0]     cand;

  // Pick the first occupied holding register after the last winner (state only).
  always_comb begin
    win      = '0;
    win_any  = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_sum = {1'b0, last_grant_q} + SW'(k);
      if (cand_sum >= SW'(N_REQ)) begin
        cand_sum = cand_sum - SW'(N_REQ);
      end
      cand = cand_sum[GW-1:0];
      if (!win_any && hold_valid_q[cand]) begin
        win[cand] = 1'b1;
        win_any   = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A slot can accept when empty or when it is being drained this cycle.
  always_comb begin
    ready  = ~hold_valid_q | win;
    accept = bus.req_valid & ready;
  end

  // Holding-register update, memory-port issue and bookkeeping.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        hold_valid_d[i] = 1'b0;
      end
      if (accept[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_addr_d[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        hold_data_d[i]  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    mem_we_d     = win_any;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wr_count_d   = wr_count_q;
    if (win_any) begin
      mem_addr_d   = hold_addr_q[win_idx];
      mem_wdata_d  = hold_data_q[win_idx];
      grant_id_d   = win_idx;
      last_grant_d = win_idx;
      wr_count_d   = wr_count_q + 16'd1;
    end
  end

  // State registers; reset discards pending entries and points priority at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hold_addr_q[i] <= '0;
        hold_data_q[i] <= '0;
      end
      last_grant_q <= GW'(N_REQ - 1);
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      grant_id_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      grant_id_q   <= grant_id_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = |hold_valid_q;
  assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_dm_wr_arbiter.sv
// Directed bench for dm_wr_arbiter: vector table for reset, streaming,
// round-robin and fairness, then hand-written mid-run reset and counter wrap.
module tb_dm_wr_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dm_wr_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_wr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [7:0]  abase;
    logic [15:0] dbase;
    logic        exp_we;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [3:0]  exp_ready;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Requester i drives address abase+i and data dbase+i.
  function automatic void addVec(logic r, logic [3:0] v, logic [7:0] ab, logic [15:0] db,
                                 logic we, logic [1:0] gid, logic [7:0] ea, logic [15:0] ed,
                                 logic [3:0] erdy, logic eb, logic [15:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.abase = ab; t.dbase = db;
    t.exp_we = we; t.exp_gid = gid; t.exp_addr = ea; t.exp_wdata = ed;
    t.exp_ready = erdy; t.exp_busy = eb; t.exp_cnt = ec;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst = t.rst;
    bus.req_valid = t.valid;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = t.abase + 8'(i);
      bus.req_data[i*DATA_W +: DATA_W] = t.dbase + 16'(i);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int writes_seen;
  int seq_bad;
  int exp_next;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // rst, valid, abase, dbase | we, gid, addr, wdata, ready, busy, count
    addVec(1, 4'hF, 8'h40, 16'hA000, 0, 0, 8'h00, 16'h0000, 4'hF, 0, 0);
    addVec(1, 4'hF, 8'h40, 16'hA000, 0, 0, 8'h00, 16'h0000, 4'hF, 0, 0);
    addVec(0, 4'h0, 8'h40, 16'hA000, 0, 0, 8'h00, 16'h0000, 4'hF, 0, 0);
    addVec(0, 4'h4, 8'h0E, 16'hBEED, 0, 0, 8'h00, 16'h0000, 4'hF, 1, 0);
    addVec(0, 4'h4, 8'h0F, 16'hBEEE, 1, 2, 8'h10, 16'hBEEF, 4'hF, 1, 1);
    addVec(0, 4'h4, 8'h10, 16'hBEEF, 1, 2, 8'h11, 16'hBEF0, 4'hF, 1, 2);
    addVec(0, 4'h4, 8'h11, 16'hBEF0, 1, 2, 8'h12, 16'hBEF1, 4'hF, 1, 3);
    addVec(0, 4'h0, 8'h11, 16'hBEF0, 1, 2, 8'h13, 16'hBEF2, 4'hF, 0, 4);
    addVec(0, 4'h0, 8'h11, 16'hBEF0, 0, 2, 8'h13, 16'hBEF2, 4'hF, 0, 4);
    addVec(1, 4'h0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 4'hF, 0, 0);
    addVec(0, 4'hF, 8'h20, 16'h1000, 0, 0, 8'h00, 16'h0000, 4'h1, 1, 0);
    addVec(0, 4'h0, 8'h20, 16'h1000, 1, 0, 8'h20, 16'h1000, 4'h3, 1, 1);
    addVec(0, 4'h0, 8'h20, 16'h1000, 1, 1, 8'h21, 16'h1001, 4'h7, 1, 2);
    addVec(0, 4'h0, 8'h20, 16'h1000, 1, 2, 8'h22, 16'h1002, 4'hF, 1, 3);
    addVec(0, 4'h0, 8'h20, 16'h1000, 1, 3, 8'h23, 16'h1003, 4'hF, 0, 4);
    addVec(0, 4'h0, 8'h20, 16'h1000, 0, 3, 8'h23, 16'h1003, 4'hF, 0, 4);
    addVec(0, 4'h9, 8'h30, 16'h2000, 0, 3, 8'h23, 16'h1003, 4'h7, 1, 4);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 0, 8'h30, 16'h2000, 4'hE, 1, 5);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 3, 8'h33, 16'h2003, 4'h7, 1, 6);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 0, 8'h30, 16'h2000, 4'hE, 1, 7);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 3, 8'h33, 16'h2003, 4'h7, 1, 8);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 0, 8'h30, 16'h2000, 4'hE, 1, 9);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 3, 8'h33, 16'h2003, 4'h7, 1, 10);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 0, 8'h30, 16'h2000, 4'hE, 1, 11);
    addVec(0, 4'h9, 8'h30, 16'h2000, 1, 3, 8'h33, 16'h2003, 4'h7, 1, 12);
    addVec(0, 4'h0, 8'h30, 16'h2000, 1, 0, 8'h30, 16'h2000, 4'hF, 1, 13);
    addVec(0, 4'h0, 8'h30, 16'h2000, 1, 3, 8'h33, 16'h2003, 4'hF, 0, 14);

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v]);
      tick();
      checkOutput($sformatf("v%0d mem_we", v),    32'(bus.mem_we),    32'(vecs[v].exp_we));
      checkOutput($sformatf("v%0d grant_id", v),  32'(bus.grant_id),  32'(vecs[v].exp_gid));
      checkOutput($sformatf("v%0d mem_addr", v),  32'(bus.mem_addr),  32'(vecs[v].exp_addr));
      checkOutput($sformatf("v%0d mem_wdata", v), 32'(bus.mem_wdata), 32'(vecs[v].exp_wdata));
      checkOutput($sformatf("v%0d req_ready", v), 32'(bus.req_ready), 32'(vecs[v].exp_ready));
      checkOutput($sformatf("v%0d busy", v),      32'(bus.busy),      32'(vecs[v].exp_busy));
      checkOutput($sformatf("v%0d wr_count", v),  32'(bus.wr_count),  32'(vecs[v].exp_cnt));
    end

    // Reset in the middle of a burst: 1/2/3 pending, 0 just written.
    rst = 1'b1; bus.req_valid = 4'h0;
    tick();
    rst = 1'b0; bus.req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = 8'h50 + 8'(i);
      bus.req_data[i*DATA_W +: DATA_W] = 16'h5000 + 16'(i);
    end
    tick();
    bus.req_valid = 4'h0;
    tick();
    checkOutput("midrst pre we",  32'(bus.mem_we),   32'd1);
    checkOutput("midrst pre gid", 32'(bus.grant_id), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst we",    32'(bus.mem_we),    32'd0);
    checkOutput("midrst busy",  32'(bus.busy),      32'd0);
    checkOutput("midrst count", 32'(bus.wr_count),  32'd0);
    checkOutput("midrst ready", 32'(bus.req_ready), 32'hF);
    writes_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.mem_we) writes_seen++;
    end
    checkOutput("midrst no writes", 32'(writes_seen), 32'd0);
    checkOutput("midrst busy end",  32'(bus.busy),    32'd0);

    // Counter wrap: 65537 streamed writes from requester 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    writes_seen = 0;
    seq_bad = 0;
    exp_next = 0;
    for (int i = 0; i < 65537; i++) begin
      bus.req_valid = 4'b0010;
      bus.req_addr[1*ADDR_W +: ADDR_W] = 8'(i);
      bus.req_data[1*DATA_W +: DATA_W] = 16'(i);
      tick();
      if (!bus.req_ready[1]) seq_bad++;
      if (bus.mem_we) begin
        if (bus.mem_addr !== 8'(exp_next) || bus.mem_wdata !== 16'(exp_next) ||
            bus.grant_id !== 2'd1) seq_bad++;
        exp_next++;
        writes_seen++;
        if (writes_seen == 65536) checkOutput("wrap count zero", 32'(bus.wr_count), 32'd0);
      end
    end
    bus.req_valid = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.mem_we) begin
        if (bus.mem_addr !== 8'(exp_next) || bus.mem_wdata !== 16'(exp_next)) seq_bad++;
        exp_next++;
        writes_seen++;
      end
    end
    checkOutput("wrap writes seen", 32'(writes_seen),  32'd65537);
    checkOutput("wrap sequence",    32'(seq_bad),      32'd0);
    checkOutput("wrap count",       32'(bus.wr_count), 32'd1);
    checkOutput("wrap busy",        32'(bus.busy),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
